// File: rtl/femto_pkg.sv
// Shared femtoRV32 datapath definitions: mux mode encodings and a width helper.
package femto_pkg;

  localparam logic MUX_MODE_SEL = 1'b0;
  localparam logic MUX_MODE_RR  = 1'b1;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nx1_reg_if.sv
// Handshake bus for the N-input registered mux: producer side in, consumer side out.
interface mux_arb_nx1_reg_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int SELW = (femto_pkg::clog2(N) < 1) ? 1 : femto_pkg::clog2(N);

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            rr_en;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_src;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_data, in_valid, rr_en, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, rr_en, sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/mux_arb_nx1_reg_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester after ptr.
module rr_arbiter
  import femto_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt
);

  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx] && !found) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nx1_reg.sv
// N-to-1 registered mux with explicit-select or round-robin arbitration and a
// single-entry output register; one word per cycle sustained.
module mux_arb_nx1_reg
  import femto_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32,
  localparam int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  mux_arb_nx1_reg_if.slave  bus
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_src_q,  out_src_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [N-1:0] gnt_sel, gnt_rr, gnt, rdy;
  logic         free, accept;
  logic [W-1:0] data_mux;

  rr_arbiter #(.N(N)) u_arb (
    .req (bus.in_valid),
    .ptr (ptr_q),
    .gnt (gnt_rr)
  );

  // Out-of-range select grants nothing rather than aliasing a channel.
  always_comb begin
    gnt_sel = '0;
    if (int'(bus.sel) < N) gnt_sel[bus.sel] = bus.in_valid[bus.sel];
  end

  assign gnt    = (bus.rr_en == MUX_MODE_RR) ? gnt_rr : gnt_sel;
  assign free   = !out_valid_q || bus.out_ready;
  assign rdy    = rst ? '0 : (gnt & {N{free}});
  assign accept = |rdy;

  always_comb begin
    data_mux  = '0;
    out_src_d = out_src_q;
    for (int i = 0; i < N; i++) begin
      data_mux = data_mux | (bus.in_data[i*W +: W] & {W{rdy[i]}});
      if (rdy[i]) out_src_d = SELW'(i);
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = data_mux;
      out_valid_d = 1'b1;
      if (bus.rr_en == MUX_MODE_RR) ptr_d = out_src_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(N-1);
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_nx1_reg.sv
// Directed plus randomized checks of mux_arb_nx1_reg against a cycle-level reference model.
module tb_mux_arb_nx1_reg;
  localparam int N = 4;
  localparam int W = 32;
  localparam int SELW = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  // reference state
  int          m_v, m_src, m_ptr;
  logic [W-1:0] m_data;

  mux_arb_nx1_reg_if #(.N(N), .W(W)) bus ();

  mux_arb_nx1_reg #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    if (bus.rr_en) begin
      for (int k = 1; k <= N && g < 0; k++)
        if (bus.in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end else if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin
      g = int'(bus.sel);
    end
    return g;
  endfunction

  // One clock: check combinational ready, clock, advance model, check registers.
  task automatic step();
    int   g;
    logic free;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] d;
    #1;
    free    = (m_v == 0) || bus.out_ready;
    g       = model_grant();
    exp_rdy = '0;
    if (!rst && free && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    d = (g >= 0) ? bus.in_data[g*W +: W] : '0;
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_data = '0; m_src = 0; m_ptr = N-1;
    end else if (exp_rdy != 0) begin
      m_v = 1; m_data = d; m_src = g;
      if (bus.rr_en) m_ptr = g;
    end else if (m_v != 0 && bus.out_ready) begin
      m_v = 0;
    end
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_v));
    chk("out_data",  64'(bus.out_data),  64'(m_data));
    chk("out_src",   64'(bus.out_src),   64'(m_src));
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 4'b1111;
    step();
    step();
    chk("rst_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held;
    rst = 1'b1;
    bus.in_data = '0; bus.in_valid = '0; bus.rr_en = 1'b1;
    bus.sel = '0; bus.out_ready = 1'b1;
    m_v = 0; m_data = '0; m_src = 0; m_ptr = N-1;

    // reset, then first round-robin grant is channel 0
    rand_data();
    do_reset();
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_data",  64'(bus.out_data),  64'(0));
    bus.in_valid = 4'b1111; bus.rr_en = 1'b1;
    step();
    chk("first_rr_src", 64'(bus.out_src), 64'(0));

    // select mode
    do_reset();
    bus.rr_en = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b0100;
    bus.in_data[2*W +: W] = 32'hDEADBEEF;
    #1 chk("sel_ready", 64'(bus.in_ready), 64'(4'b0100));
    step();
    chk("sel_data", 64'(bus.out_data), 64'(32'hDEADBEEF));
    chk("sel_src",  64'(bus.out_src),  64'(2));
    bus.sel = 2'd1;
    step();
    chk("sel_miss_valid", 64'(bus.out_valid), 64'(0));

    // round-robin fairness: 0,1,2,3,0,1,2,3 with no bubbles
    do_reset();
    bus.rr_en = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      step();
      chk("fair_src",   64'(bus.out_src),   64'(c % N));
      chk("fair_valid", 64'(bus.out_valid), 64'(1));
    end

    // backpressure then simultaneous pop and accept
    bus.out_ready = 1'b0;
    held = bus.out_data;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      step();
      chk("bp_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_data",  64'(bus.out_data), 64'(held));
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_valid", 64'(bus.out_valid), 64'(1));

    // sparse requests and wrap
    do_reset();
    bus.rr_en = 1'b1; bus.in_valid = 4'b0010;
    step();
    chk("sparse_src", 64'(bus.out_src), 64'(1));
    bus.in_valid = 4'b0011;
    step();
    chk("wrap_src", 64'(bus.out_src), 64'(0));

    // mode switch keeps ptr
    do_reset();
    bus.rr_en = 1'b1; bus.in_valid = 4'b0100;
    step();
    chk("ms_rr_src", 64'(bus.out_src), 64'(2));
    bus.rr_en = 1'b0; bus.sel = 2'd3; bus.in_valid = 4'b1000;
    step();
    step();
    chk("ms_sel_src", 64'(bus.out_src), 64'(3));
    bus.rr_en = 1'b1; bus.in_valid = 4'b1111;
    step();
    chk("ms_resume_src", 64'(bus.out_src), 64'(3));

    // randomized traffic, including occasional mid-stream reset
    for (int c = 0; c < 400; c++) begin
      rand_data();
      bus.in_valid  = N'($urandom);
      bus.rr_en     = 1'($urandom_range(0, 1));
      bus.sel       = SELW'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
